// File: rtl/transmisor_dac_pkg.sv
// Shared constants and state encoding for the filter-output DAC transmitter.
package transmisor_dac_pkg;

  localparam int         DAC_W     = 12;
  localparam int         FRAME_W   = 16;
  localparam logic [3:0] CTRL_BITS = 4'b0000;  // load DAC A, normal mode

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } estado_t;

endpackage

// File: rtl/saturador_dac.sv
// Signed fixed-point sample to offset-binary DAC code, saturating outside [-1.0, +1.0).
module saturador_dac #(
  parameter int N     = 25,
  parameter int FRAC  = 15,
  parameter int DAC_W = 12
) (
  input  logic [N-1:0]     yk,
  output logic [DAC_W-1:0] code
);

  logic             fuera;
  logic [DAC_W-1:0] s;
  logic             unused_lsb;

  // Integer bits plus the sign must all agree for the value to fit the DAC range.
  assign fuera      = (yk[N-1:FRAC] != {(N-FRAC){yk[N-1]}});
  assign unused_lsb = ^yk[FRAC-DAC_W:0];

  always_comb begin
    s = yk[FRAC -: DAC_W];
    if (fuera) begin
      s = yk[N-1] ? {1'b1, {(DAC_W-1){1'b0}}} : {1'b0, {(DAC_W-1){1'b1}}};
    end
    code = {~s[DAC_W-1], s[DAC_W-2:0]};
  end

endmodule

// File: rtl/transmisor_dac_spi.sv
// Takes filtered samples, converts them to DAC codes and shifts them out as
// 16-bit SPI frames (SCLK idles high, DAC samples on SCLK falling edge).
module transmisor_dac_spi
  import transmisor_dac_pkg::*;
#(
  parameter int N    = 25,
  parameter int FRAC = 15,
  parameter int DIV  = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [N-1:0] Yk,
  input  logic         Bandera_Listo,
  output logic         SCLK,
  output logic         SDATA,
  output logic         SYNC_n,
  output logic         Ocupado,
  output logic         Bandera_Enviado,
  output logic         Sobrecarga,
  output estado_t      estado_dbg
);

  // Handshake: Bandera_Listo is a valid-only strobe with no back-pressure; every
  // cycle it is high captures Yk. Ocupado is informational, and a capture while a
  // sample is still pending replaces it and raises Sobrecarga for one cycle.

  localparam int            CW      = $clog2(2*DIV+1);
  localparam logic [CW-1:0] DIV_END = CW'(DIV-1);
  localparam logic [CW-1:0] GAP_END = CW'(2*DIV-1);

  estado_t              estado, estado_sig;
  logic [N-1:0]         hold, hold_sig;
  logic                 pendiente, pendiente_sig;
  logic [FRAME_W-1:0]   shreg, shreg_sig;
  logic [3:0]           bit_cnt, bit_sig;
  logic [CW-1:0]        div_cnt, div_sig;
  logic                 sclk_sig, sdata_sig, sync_sig, ocup_sig, env_sig, sob_sig;
  logic                 carga;
  logic                 tick;
  logic [DAC_W-1:0]     code;
  logic [FRAME_W-1:0]   frame;

  saturador_dac #(.N(N), .FRAC(FRAC), .DAC_W(DAC_W)) u_sat (
    .yk   (hold),
    .code (code)
  );

  assign frame      = {CTRL_BITS, code};
  assign tick       = (div_cnt == DIV_END);
  assign estado_dbg = estado;

  always_comb begin
    estado_sig = estado;
    shreg_sig  = shreg;
    bit_sig    = bit_cnt;
    div_sig    = div_cnt;
    sclk_sig   = SCLK;
    sdata_sig  = SDATA;
    sync_sig   = SYNC_n;
    ocup_sig   = Ocupado;
    env_sig    = 1'b0;
    carga      = 1'b0;

    case (estado)
      IDLE: begin
        if (pendiente) begin
          carga      = 1'b1;
          shreg_sig  = frame;
          sdata_sig  = frame[FRAME_W-1];
          sync_sig   = 1'b0;
          ocup_sig   = 1'b1;
          sclk_sig   = 1'b1;
          bit_sig    = 4'(FRAME_W-1);
          div_sig    = '0;
          estado_sig = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          div_sig = '0;
          if (SCLK) begin
            sclk_sig = 1'b0;
          end else if (bit_cnt == 4'd0) begin
            // Rising edge after the 16th falling edge closes the frame.
            sclk_sig   = 1'b1;
            sync_sig   = 1'b1;
            sdata_sig  = 1'b0;
            estado_sig = GAP;
          end else begin
            sclk_sig  = 1'b1;
            bit_sig   = bit_cnt - 4'd1;
            sdata_sig = shreg[bit_cnt - 4'd1];
          end
        end else begin
          div_sig = div_cnt + 1'b1;
        end
      end
      GAP: begin
        if (div_cnt == GAP_END) begin
          div_sig    = '0;
          ocup_sig   = 1'b0;
          env_sig    = 1'b1;
          estado_sig = IDLE;
        end else begin
          div_sig = div_cnt + 1'b1;
        end
      end
      default: estado_sig = IDLE;
    endcase

    // A same-edge capture wins over the load that clears pendiente.
    hold_sig      = Bandera_Listo ? Yk : hold;
    pendiente_sig = Bandera_Listo | (pendiente & ~carga);
    sob_sig       = Bandera_Listo & pendiente & ~carga;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      estado          <= IDLE;
      hold            <= '0;
      pendiente       <= 1'b0;
      shreg           <= '0;
      bit_cnt         <= '0;
      div_cnt         <= '0;
      SCLK            <= 1'b1;
      SDATA           <= 1'b0;
      SYNC_n          <= 1'b1;
      Ocupado         <= 1'b0;
      Bandera_Enviado <= 1'b0;
      Sobrecarga      <= 1'b0;
    end else begin
      estado          <= estado_sig;
      hold            <= hold_sig;
      pendiente       <= pendiente_sig;
      shreg           <= shreg_sig;
      bit_cnt         <= bit_sig;
      div_cnt         <= div_sig;
      SCLK            <= sclk_sig;
      SDATA           <= sdata_sig;
      SYNC_n          <= sync_sig;
      Ocupado         <= ocup_sig;
      Bandera_Enviado <= env_sig;
      Sobrecarga      <= sob_sig;
    end
  end

endmodule
